// File: rtl/pkt_pkg.sv
// Shared types and constants for the UDP transmit frame builder.
package pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_HDR,
        ST_PAY,
        ST_FLUSH,
        ST_DROP
    } state_e;

    localparam int unsigned HDR_BYTES      = 42;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

    // ceil(len/8) without overflowing 16 bits near 0xFFFF
    function automatic logic [15:0] words_for_len(input logic [15:0] len);
        return {3'b000, len[15:3]} + {15'd0, |len[2:0]};
    endfunction

    function automatic logic [2:0] empty_for_len(input logic [15:0] len);
        logic [15:0] tot;
        tot = len + 16'(HDR_BYTES);
        return 3'(3'd0 - tot[2:0]);
    endfunction

endpackage

// File: rtl/udp_frame_builder_if.sv
// Streaming bus bundle for udp_frame_builder: length/destination request,
// payload word input and frame beat output. master = the frame builder.
interface udp_frame_builder_if;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [15:0] len_in;
    logic        len_valid;
    logic        len_ready;
    logic [63:0] pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready_out;
    logic        start_packet;
    logic        end_packet;
    logic [2:0]  empty;
    logic        drop;

    modport master (
        input  dst_mac, dst_ip, dst_port, len_in, len_valid, pay_data, pay_valid, ready_out,
        output len_ready, pay_ready, data_out, valid_out, start_packet, end_packet, empty, drop
    );

    modport slave (
        output dst_mac, dst_ip, dst_port, len_in, len_valid, pay_data, pay_valid, ready_out,
        input  len_ready, pay_ready, data_out, valid_out, start_packet, end_packet, empty, drop
    );
endinterface

// File: rtl/ipv4_hdr_csum.sv
// Combinational IPv4 header checksum (ones-complement fold of ten words).
// Only built when UDP_FRAME_IP_CSUM_EN is defined; otherwise the checksum is zero.
`ifdef UDP_FRAME_IP_CSUM_EN
module ipv4_hdr_csum
    import pkt_pkg::*;
#(
    parameter logic [7:0] TTL = 8'd64
) (
    input  logic [15:0] total_len_i,
    input  logic [15:0] ip_id_i,
    input  logic [31:0] src_ip_i,
    input  logic [31:0] dst_ip_i,
    output logic [15:0] csum_o
);
    logic [31:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = 32'({IP_VER_IHL, 8'h00}) + 32'(total_len_i) + 32'(ip_id_i)
            + 32'(IP_FLAGS_DF) + 32'({TTL, IP_PROTO_UDP})
            + 32'(src_ip_i[31:16]) + 32'(src_ip_i[15:0])
            + 32'(dst_ip_i[31:16]) + 32'(dst_ip_i[15:0]);
        // sum < 2^20, so two end-around folds always settle
        fold1  = 17'(sum[31:16]) + 17'(sum[15:0]);
        fold2  = fold1[15:0] + 16'(fold1[16]);
        csum_o = ~fold2;
    end
endmodule
`endif

// File: rtl/udp_frame_builder.sv
// Builds Ethernet II / IPv4 / UDP frames as 64-bit beats from a length request
// and a payload word stream. Optional header checksum: UDP_FRAME_IP_CSUM_EN.
module udp_frame_builder
    import pkt_pkg::*;
#(
    parameter logic [47:0] SRC_MAC     = 48'h0002_0304_0506,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_0001,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input logic                 clk,
    input logic                 reset,
    udp_frame_builder_if.master bus
);
    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [47:0] dmac_q, dmac_d;
    logic [31:0] dip_q, dip_d;
    logic [15:0] dport_q, dport_d;
    logic [15:0] ip_id_q, ip_id_d;
    logic [15:0] csum_q, csum_d;
    logic [2:0]  hidx_q, hidx_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] res_q, res_d;
    logic [63:0] dout_q, dout_d;
    logic        vout_q, vout_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [2:0]  empty_q, empty_d;
    logic        drop_q, drop_d;

    logic        pay_ready_c;
    logic        can_load, xfer, last_word, flush_needed, last_pending;
    logic [15:0] n_words, total_len, udp_len, csum_calc;

    assign total_len = len_q + 16'd28;
    assign udp_len   = len_q + 16'd8;

`ifdef UDP_FRAME_IP_CSUM_EN
    ipv4_hdr_csum #(.TTL(TTL)) u_csum (
        .total_len_i (total_len),
        .ip_id_i     (ip_id_q),
        .src_ip_i    (SRC_IP),
        .dst_ip_i    (dip_q),
        .csum_o      (csum_calc)
    );
`else
    assign csum_calc = '0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        dmac_d      = dmac_q;
        dip_d       = dip_q;
        dport_d     = dport_q;
        ip_id_d     = ip_id_q;
        csum_d      = csum_q;
        hidx_d      = hidx_q;
        wcnt_d      = wcnt_q;
        res_d       = res_q;
        dout_d      = dout_q;
        vout_d      = vout_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        empty_d     = empty_q;
        drop_d      = 1'b0;
        pay_ready_c = 1'b0;

        can_load     = !vout_q || bus.ready_out;
        xfer         = vout_q && bus.ready_out;
        n_words      = words_for_len(len_q);
        last_word    = (wcnt_q == n_words - 16'd1);
        flush_needed = (len_q != 16'd0) && ((len_q[2:0] == 3'd7) || (len_q[2:0] == 3'd0));
        last_pending = vout_q && eop_q;

        if (xfer) begin
            vout_d  = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            empty_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.len_valid) begin
                    len_d   = bus.len_in;
                    dmac_d  = bus.dst_mac;
                    dip_d   = bus.dst_ip;
                    dport_d = bus.dst_port;
                    wcnt_d  = '0;
                    state_d = (bus.len_in > 16'(MAX_PAYLOAD)) ? ST_DROP : ST_CALC;
                end
            end
            ST_CALC: begin
                csum_d  = csum_calc;
                dout_d  = {dmac_q, SRC_MAC[47:32]};
                vout_d  = 1'b1;
                sop_d   = 1'b1;
                hidx_d  = 3'd1;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                if (can_load) begin
                    vout_d = 1'b1;
                    unique case (hidx_q)
                        3'd1:    dout_d = {SRC_MAC[31:0], ETHERTYPE_IPV4, IP_VER_IHL, 8'h00};
                        3'd2:    dout_d = {total_len, ip_id_q, IP_FLAGS_DF, TTL, IP_PROTO_UDP};
                        3'd3:    dout_d = {csum_q, SRC_IP, dip_q[31:16]};
                        default: dout_d = {dip_q[15:0], SRC_PORT, dport_q, udp_len};
                    endcase
                    if (hidx_q == 3'd4) begin
                        res_d   = '0;
                        wcnt_d  = '0;
                        state_d = ST_PAY;
                    end else begin
                        hidx_d = hidx_q + 3'd1;
                    end
                end
            end
            ST_PAY: begin
                if (last_pending) begin
                    if (bus.ready_out) begin
                        ip_id_d = ip_id_q + 16'd1;
                        state_d = ST_IDLE;
                    end
                end else if (can_load) begin
                    if (len_q == 16'd0) begin
                        dout_d  = '0;
                        vout_d  = 1'b1;
                        eop_d   = 1'b1;
                        empty_d = empty_for_len(len_q);
                    end else begin
                        pay_ready_c = 1'b1;
                        // Each beat carries the previous word's tail and the new word's head
                        if (bus.pay_valid) begin
                            dout_d = {res_q, bus.pay_data[63:16]};
                            vout_d = 1'b1;
                            res_d  = bus.pay_data[15:0];
                            wcnt_d = wcnt_q + 16'd1;
                            if (last_word) begin
                                if (flush_needed) begin
                                    state_d = ST_FLUSH;
                                end else begin
                                    eop_d   = 1'b1;
                                    empty_d = empty_for_len(len_q);
                                end
                            end
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (last_pending) begin
                    if (bus.ready_out) begin
                        ip_id_d = ip_id_q + 16'd1;
                        state_d = ST_IDLE;
                    end
                end else if (can_load) begin
                    dout_d  = {res_q, 48'h0};
                    vout_d  = 1'b1;
                    eop_d   = 1'b1;
                    empty_d = empty_for_len(len_q);
                end
            end
            ST_DROP: begin
                pay_ready_c = 1'b1;
                if (bus.pay_valid) begin
                    wcnt_d = wcnt_q + 16'd1;
                    if (last_word) begin
                        drop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            dmac_q  <= '0;
            dip_q   <= '0;
            dport_q <= '0;
            ip_id_q <= '0;
            csum_q  <= '0;
            hidx_q  <= '0;
            wcnt_q  <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            dmac_q  <= dmac_d;
            dip_q   <= dip_d;
            dport_q <= dport_d;
            ip_id_q <= ip_id_d;
            csum_q  <= csum_d;
            hidx_q  <= hidx_d;
            wcnt_q  <= wcnt_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            empty_q <= empty_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.len_ready    = (state_q == ST_IDLE);
    assign bus.pay_ready    = pay_ready_c;
    assign bus.data_out     = dout_q;
    assign bus.valid_out    = vout_q;
    assign bus.start_packet = sop_q;
    assign bus.end_packet   = eop_q;
    assign bus.empty        = empty_q;
    assign bus.drop         = drop_q;

endmodule

// File: tb/tb_udp_frame_builder.sv
// Scoreboard bench for udp_frame_builder: a byte-level frame model fills the
// expected-beat queue, an independent monitor pops and compares accepted beats.
module tb_udp_frame_builder;

    localparam logic [47:0] SRC_MAC  = 48'h0002_0304_0506;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_0001;
    localparam logic [15:0] SRC_PORT = 16'd5000;
    localparam logic [7:0]  TTL      = 8'd64;
    localparam int          MAXP     = 1472;

    typedef struct {
        logic [63:0] data;
        int          nvalid;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    udp_frame_builder_if bus ();

    udp_frame_builder #(
        .SRC_MAC     (SRC_MAC),
        .SRC_IP      (SRC_IP),
        .SRC_PORT    (SRC_PORT),
        .TTL         (TTL),
        .MAX_PAYLOAD (MAXP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    beat_t       exp_q[$];
    logic [63:0] word_q[$];
    logic [63:0] cur_words[$];
    logic [15:0] model_id;
    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int rmode = 0;
    int frames_done = 0, drops_seen = 0, words_used = 0;
    int beats_done = 0, last_beats = 0;
    logic [2:0]  last_empty;
    logic [63:0] beat3_data;
    logic l0_active = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Reference: assemble the frame as a byte list, then cut into 8-byte beats
    task automatic model_frame(input int L, input logic [47:0] dmac, input logic [31:0] dip,
                               input logic [15:0] dport, input logic [15:0] id);
        logic [7:0]  fr[$];
        logic [15:0] tl, ul;
        beat_t b;
        int nb;
        tl = 16'(L + 28);
        ul = 16'(L + 8);
        for (int i = 5; i >= 0; i--) fr.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(SRC_MAC[8*i +: 8]);
        fr.push_back(8'h08); fr.push_back(8'h00); fr.push_back(8'h45); fr.push_back(8'h00);
        fr.push_back(tl[15:8]); fr.push_back(tl[7:0]); fr.push_back(id[15:8]); fr.push_back(id[7:0]);
        fr.push_back(8'h40); fr.push_back(8'h00); fr.push_back(TTL); fr.push_back(8'h11);
        fr.push_back(8'h00); fr.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fr.push_back(SRC_IP[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fr.push_back(dip[8*i +: 8]);
        fr.push_back(SRC_PORT[15:8]); fr.push_back(SRC_PORT[7:0]);
        fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
        fr.push_back(ul[15:8]); fr.push_back(ul[7:0]);
        fr.push_back(8'h00); fr.push_back(8'h00);
`ifdef UDP_FRAME_IP_CSUM_EN
        begin
            int s;
            logic [15:0] cs;
            s = 0;
            for (int i = 14; i < 34; i += 2) s += int'({fr[i], fr[i+1]});
            while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
            cs = ~16'(s);
            fr[24] = cs[15:8];
            fr[25] = cs[7:0];
        end
`endif
        for (int p = 0; p < L; p++) begin
            logic [63:0] w;
            w = cur_words[p / 8];
            fr.push_back(w[63 - 8*(p % 8) -: 8]);
        end
        nb = (fr.size() + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            b.data = '0;
            for (int k = 0; k < 8; k++)
                if (bi*8 + k < fr.size()) b.data[63 - 8*k -: 8] = fr[bi*8 + k];
            b.nvalid = (fr.size() - bi*8 >= 8) ? 8 : fr.size() - bi*8;
            b.sop    = (bi == 0);
            b.eop    = (bi == nb - 1);
            b.empty  = 3'(8 - b.nvalid);
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       bus.ready_out = 1'b1;
            1:       bus.ready_out = ~bus.ready_out;
            default: bus.ready_out = 1'($urandom_range(0, 1));
        endcase
    end

    always @(posedge clk) begin
        #1;
        if (!reset && word_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            bus.pay_valid = 1'b1;
            bus.pay_data  = word_q[0];
        end else begin
            bus.pay_valid = 1'b0;
            bus.pay_data  = {$urandom, $urandom};
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.pay_valid && bus.pay_ready) begin
            void'(word_q.pop_front());
            words_used++;
        end
    end

    // Monitor: beat compare, hold-under-backpressure, first-beat latency
    logic        prev_hold = 1'b0;
    logic [63:0] prev_data;
    logic        prev_sop, prev_eop;
    logic [2:0]  prev_empty;
    logic        lat_pend = 1'b0;
    int          lat_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            beats_done = 0;
            lat_pend   = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(bus.valid_out), 64'd1);
                chk("hold_data", bus.data_out, prev_data);
                chk("hold_flags", {bus.start_packet, bus.end_packet, bus.empty},
                    {prev_sop, prev_eop, prev_empty});
            end
            prev_hold  = bus.valid_out && !bus.ready_out;
            prev_data  = bus.data_out;
            prev_sop   = bus.start_packet;
            prev_eop   = bus.end_packet;
            prev_empty = bus.empty;

            if (bus.valid_out && lat_pend) begin
                chk("first_beat_latency", 64'(cyc), 64'(lat_cyc + 2));
                lat_pend = 1'b0;
            end
            if (bus.len_valid && bus.len_ready) begin
                lat_pend = 1'b1;
                lat_cyc  = cyc;
            end

            if (bus.valid_out && bus.ready_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", bus.data_out, 64'hx);
                end else begin
                    beat_t e;
                    logic [63:0] mask;
                    e = exp_q.pop_front();
                    mask = '0;
                    for (int k = 0; k < e.nvalid; k++) mask[63 - 8*k -: 8] = 8'hFF;
                    chk("beat_data", bus.data_out & mask, e.data & mask);
                    chk("beat_sop_eop_empty", {bus.start_packet, bus.end_packet, bus.empty},
                        {e.sop, e.eop, e.empty});
                end
                if (beats_done == 3) beat3_data = bus.data_out;
                beats_done++;
                if (bus.end_packet) begin
                    last_beats  = beats_done;
                    last_empty  = bus.empty;
                    beats_done  = 0;
                    frames_done++;
                end
            end
            if (bus.drop) drops_seen++;
            if (l0_active) chk("l0_pay_ready", 64'(bus.pay_ready), 64'd0);
        end
    end

    task automatic issue_len(input int L, input logic [47:0] dmac, input logic [31:0] dip,
                             input logic [15:0] dport);
        bit ok;
        @(posedge clk); #1;
        bus.len_in    = 16'(L);
        bus.dst_mac   = dmac;
        bus.dst_ip    = dip;
        bus.dst_port  = dport;
        bus.len_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.len_ready) ok = 1'b1;
        end
        if (!ok) chk("len_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.len_valid = 1'b0;
    endtask

    task automatic prep_frame(input int L, input logic [47:0] dmac, input logic [31:0] dip,
                              input logic [15:0] dport);
        int n;
        n = (L + 7) / 8;
        cur_words.delete();
        for (int i = 0; i < n; i++) cur_words.push_back({$urandom, $urandom});
        if (L <= MAXP) begin
            model_frame(L, dmac, dip, dport, model_id);
            model_id = model_id + 16'd1;
        end
        foreach (cur_words[i]) word_q.push_back(cur_words[i]);
    endtask

    task automatic send_frame(input int L, input logic [47:0] dmac, input logic [31:0] dip,
                              input logic [15:0] dport, input int rm);
        int fd0, dr0, wu0;
        bit done;
        rmode = rm;
        fd0 = frames_done;
        dr0 = drops_seen;
        wu0 = words_used;
        l0_active = (L == 0);
        prep_frame(L, dmac, dip, dport);
        issue_len(L, dmac, dip, dport);
        done = 1'b0;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(posedge clk);
            done = (L <= MAXP) ? (frames_done > fd0) : (drops_seen > dr0);
        end
        if (!done) chk("frame_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        l0_active = 1'b0;
        chk("words_consumed", 64'(words_used - wu0), 64'((L + 7) / 8));
        chk("words_left", 64'(word_q.size()), 64'd0);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        if (L > MAXP) chk("drop_pulses", 64'(drops_seen - dr0), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 900000", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        reset         = 1'b1;
        bus.len_valid = 1'b0;
        bus.len_in    = '0;
        bus.dst_mac   = '0;
        bus.dst_ip    = '0;
        bus.dst_port  = '0;
        bus.pay_valid = 1'b0;
        bus.pay_data  = '0;
        bus.ready_out = 1'b1;
        model_id      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_sop_eop", {bus.start_packet, bus.end_packet}, 64'd0);
        chk("rst_drop", 64'(bus.drop), 64'd0);
        chk("rst_pay_ready", 64'(bus.pay_ready), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd0);
        chk("rst_data_out", bus.data_out, 64'd0);
        reset = 1'b0;
        chk("idle_len_ready", 64'(bus.len_ready), 64'd1);

        send_frame(87, 48'hA1A2_A3A4_A5A6, 32'hC0A8_00C7, 16'd1234, 0);
        chk("l87_beats", 64'(last_beats), 64'd17);
        chk("l87_empty", 64'(last_empty), 64'd7);
`ifdef UDP_FRAME_IP_CSUM_EN
        chk("l87_ip_csum", 64'(beat3_data[63:48]), 64'hB861);
`else
        chk("l87_ip_csum", 64'(beat3_data[63:48]), 64'h0000);
`endif
        send_frame(0, 48'h1111_2222_3333, 32'hC0A8_00C7, 16'd53, 0);
        chk("l0_beats", 64'(last_beats), 64'd6);
        chk("l0_empty", 64'(last_empty), 64'd6);
        send_frame(6, 48'h0A0B_0C0D_0E0F, 32'h0A00_0001, 16'd80, 2);
        chk("l6_beats", 64'(last_beats), 64'd6);
        chk("l6_empty", 64'(last_empty), 64'd0);
        send_frame(16, 48'hFFFF_FFFF_FFFF, 32'h0A00_0002, 16'd9, 1);
        chk("l16_beats", 64'(last_beats), 64'd8);
        chk("l16_empty", 64'(last_empty), 64'd6);
        send_frame(1500, 48'h0101_0101_0101, 32'h0A00_0003, 16'd7, 2);
        send_frame(7, 48'h0202_0202_0202, 32'h0A00_0004, 16'd8, 0);
        send_frame(MAXP, 48'h0303_0303_0303, 32'h0A00_0005, 16'd9, 2);
        send_frame(MAXP + 1, 48'h0404_0404_0404, 32'h0A00_0006, 16'd10, 0);

        for (int f = 0; f < 24; f++) begin
            int L;
            L = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1473, 1600))
                                            : int'($urandom_range(0, 120));
            send_frame(L, {$urandom, 16'($urandom)}, $urandom, 16'($urandom),
                       int'($urandom_range(0, 2)));
        end

        // Abort a frame while beat 3 is on the bus
        rmode = 0;
        prep_frame(40, 48'h0505_0505_0505, 32'h0A00_0007, 16'd11);
        issue_len(40, 48'h0505_0505_0505, 32'h0A00_0007, 16'd11);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk); #2;
            if (beats_done == 3 && bus.valid_out) ok = 1'b1;
        end
        if (!ok) chk("beat3_timeout", 64'd0, 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_valid_out", 64'(bus.valid_out), 64'd0);
        exp_q.delete();
        word_q.delete();
        model_id = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        send_frame(20, 48'h0606_0606_0606, 32'h0A00_0008, 16'd12, 2);
        send_frame(15, 48'h0707_0707_0707, 32'h0A00_0009, 16'd13, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/udp_frame_builder.md
Name: udp_frame_builder

Overview:
Transmit-side counterpart to the receive UDP payload extractor. Takes a payload length and a stream of 64-bit payload words, then emits a complete Ethernet II / IPv4 / UDP frame as 64-bit streaming beats with start_packet, end_packet and empty. Sits between the payload source FIFO and the MAC TX streaming port.

Parameters:
SRC_MAC, 48'h0002_0304_0506, local station MAC
SRC_IP, 32'hC0A8_0001, local IPv4 address
SRC_PORT, 16'd5000, UDP source port
TTL, 8'd64, IPv4 time-to-live
MAX_PAYLOAD, 1472, largest accepted payload length in bytes

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dst_mac  in  48  destination MAC; sampled when len_in is accepted
dst_ip  in  32  destination IPv4 address; sampled when len_in is accepted
dst_port  in  16  UDP destination port; sampled when len_in is accepted
len_in  in  16  payload length L in bytes
len_valid  in  1  len_in valid
len_ready  out  1  high only in IDLE
pay_data  in  64  payload word; byte 0 in [63:56]
pay_valid  in  1  payload word valid
pay_ready  out  1  payload word consumed this cycle
data_out  out  64  frame beat; byte 0 in [63:56]
valid_out  out  1  beat valid
ready_out  in  1  downstream accepts beat
start_packet  out  1  first beat of frame
end_packet  out  1  last beat of frame
empty  out  3  unused low bytes in last beat; 0 on all other beats
drop  out  1  one-cycle pulse when an oversize frame is discarded

Behaviour:
- Reset values: valid_out, start_packet, end_packet, drop, pay_ready = 0; empty = 0; data_out = 0; ip_id = 0; state = IDLE. Reset asserted mid-frame aborts the frame at once. No end_packet is sent for the aborted frame.
- Handshakes:
  - A beat transfers when valid_out && ready_out. The output register holds while ready_out is low.
  - A payload word transfers when pay_valid && pay_ready.
  - While waiting for pay_valid, valid_out drops to 0 (bubbles are legal).
- Frame layout: 42-byte header = 14-byte Ethernet + 20-byte IPv4 + 8-byte UDP.
  - Beat 0: dst_mac, SRC_MAC[47:32].
  - Beat 1: SRC_MAC[31:0], 0x0800, 0x45, 0x00.
  - Beat 2: total_len = L+28, ip_id, 0x4000, TTL, 0x11.
  - Beat 3: ip_csum, SRC_IP, dst_ip[31:16].
  - Beat 4: dst_ip[15:0], SRC_PORT, dst_port, udp_len = L+8.
  - Beat 5: 16'h0000 (UDP checksum), then payload word 0 [63:16].
  - Beat k>5: {word k-6 [15:0], word k-5 [63:16]}.
- Counts:
  - Beat count = ceil((42+L)/8).
  - Payload words consumed = ceil(L/8). Unused low bytes of the last word are ignored.
  - empty = (8 - (42+L) mod 8) mod 8.
  - All length arithmetic is 16-bit.
- States:
  - IDLE: on len accept, latch L and dst_*. If L > MAX_PAYLOAD go to DROP, else go to CALC.
  - CALC: exactly 1 cycle, computes ip_csum. First beat is valid 2 cycles after len accept.
  - HDR: beats 0-4.
  - PAY: beat 5 onward. Beat 5 still needs a payload word when L ≥ 1. With L=0, beat 5 is the final beat, empty=6, and no word is consumed.
  - FLUSH: one extra beat carrying only the 2 residual bytes. Used when L > 0 and L mod 8 ∈ {7, 0}.
  - After the last beat is accepted: back to IDLE and ip_id increments (wraps at 16 bits).
  - DROP: consume ceil(L/8) words, emit nothing, pulse drop on the final word, return to IDLE. ip_id is unchanged.
- start_packet and end_packet assert in the same beat only if the frame is one beat long, which is impossible here (minimum 6 beats).

Optional Feature:
- Macro UDP_FRAME_IP_CSUM_EN.
- Defined: ip_csum = ones-complement of the 16-bit ones-complement sum of the ten IPv4 header words (checksum field taken as 0).
- Undefined: ip_csum = 16'h0000. CALC still takes 1 cycle, so latency is identical either way.

Decomposition:
- Shared package pkt_pkg holds:
  - the state enum;
  - HDR_BYTES = 42, ETHERTYPE_IPV4 = 16'h0800, IP_PROTO_UDP = 8'h11, IP_VER_IHL = 8'h45, IP_FLAGS_DF = 16'h4000.
- One sub-module: ipv4_hdr_csum. Purely combinational folding adder; its result is registered in CALC.

Test Plan:
- L=0, dst_ip C0A800C7, ready_out=1: 6 beats; beat 2 [63:48]=001C; beat 4 [15:0]=0008; beat 5 = 0000_xxxx... with empty=6; pay_ready never high.
- Checksum check, with SRC_IP=C0A80001, dst_ip=C0A800C7, first frame after reset (ip_id=0), L=87:
  - Macro defined: ip_csum=B861.
  - Any build: 17 beats, last is a FLUSH beat, empty=7, 11 words consumed.
- L=6: 6 beats, empty=0, 1 word consumed, beat 5 [47:0] = word0 [63:16].
- Backpressure: L=16, ready_out toggled 1/0 every cycle: all 8 beats delivered in order, data_out stable while ready_out=0; empty=6 on the last beat.
- Oversize: L=1500: no valid_out; 188 words consumed; drop pulses once. The next frame carries the same ip_id.
- Reset asserted at beat 3 of a frame: valid_out=0 in the same cycle. Next frame after release has ip_id=0 and a correct start_packet.
